// File: rtl/tlc_pkg.sv
// Shared types and constants for the main/side-street traffic light sequencer.
package tlc_pkg;

    typedef enum logic [2:0] {
        StMgA,
        StMgB,
        StMy,
        StWalk,
        StSg,
        StSgExt,
        StSy
    } state_e;

    typedef logic [3:0] interval_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Intervals wider than the timer's 4-bit load field wrap silently.
    function automatic interval_t to_interval(input int unsigned secs);
        return interval_t'(secs % 16);
    endfunction

endpackage

// File: rtl/walk_register.sv
// Set-dominant pedestrian request latch used by the traffic light sequencer.
module walk_register (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic clr_i,
    output logic latched_o
);

    logic latched_q, latched_d;

    // Set is applied last so a request arriving on the clear cycle is kept.
    always_comb begin
        latched_d = latched_q;
        if (clr_i) latched_d = 1'b0;
        if (set_i) latched_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) latched_q <= 1'b0;
        else       latched_q <= latched_d;
    end

    assign latched_o = latched_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side-street traffic light sequencer driving an external countdown timer.
// Define TLC_WALK_EN to build in the pedestrian WALK phase and request latch.
module traffic_light_fsm
    import tlc_pkg::*;
#(
    parameter int unsigned T_BASE = 6,
    parameter int unsigned T_EXT  = 3,
    parameter int unsigned T_YEL  = 2
) (
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       expired,
    input  logic       sensor,
    input  logic       walk_request,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk
);

    localparam interval_t IvBase = to_interval(T_BASE);
    localparam interval_t IvExt  = to_interval(T_EXT);
    localparam interval_t IvYel  = to_interval(T_YEL);

    state_e    state_q, state_d;
    logic      start_q, start_d;
    logic      start_prev_q;
    logic      load_pending_q;
    interval_t value_q, value_d;
    interval_t iv;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic      walk_q, walk_d;
    logic      exp_ok;
    logic      walk_latched;

`ifdef TLC_WALK_EN
    logic walk_clr;
    assign walk_clr = (state_d == StWalk) && (state_q != StWalk);

    walk_register u_walk_register (
        .clk_i     (clk),
        .rst_i     (Reset_Sync),
        .set_i     (walk_request),
        .clr_i     (walk_clr),
        .latched_o (walk_latched)
    );
`else
    logic unused_walk_request;
    assign unused_walk_request = walk_request;
    assign walk_latched        = 1'b0;
`endif

    // A stale expiry lingers while the timer reloads, so ignore it for two cycles.
    assign exp_ok = expired && !start_q && !start_prev_q && !load_pending_q;

    always_comb begin
        state_d = state_q;
        if (exp_ok) begin
            unique case (state_q)
                StMgA:   state_d = StMgB;
                StMgB:   state_d = StMy;
                StMy:    state_d = walk_latched ? StWalk : StSg;
                StWalk:  state_d = StSg;
                StSg:    state_d = sensor ? StSgExt : StSy;
                StSgExt: state_d = StSy;
                StSy:    state_d = StMgA;
                default: state_d = StMgA;
            endcase
        end
    end

    always_comb begin
        start_d = exp_ok || load_pending_q;
        main_d  = LAMP_R;
        side_d  = LAMP_R;
        walk_d  = 1'b0;
        iv      = IvBase;
        unique case (state_d)
            StMgA:   begin main_d = LAMP_G; iv = IvBase; end
            StMgB:   begin main_d = LAMP_G; iv = sensor ? IvExt : IvBase; end
            StMy:    begin main_d = LAMP_Y; iv = IvYel; end
            StWalk:  begin walk_d = 1'b1;   iv = IvExt; end
            StSg:    begin side_d = LAMP_G; iv = IvBase; end
            StSgExt: begin side_d = LAMP_G; iv = IvExt; end
            StSy:    begin side_d = LAMP_Y; iv = IvYel; end
            default: begin main_d = LAMP_G; iv = IvBase; end
        endcase
        value_d = start_d ? iv : value_q;
    end

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state_q        <= StMgA;
            start_q        <= 1'b0;
            start_prev_q   <= 1'b0;
            load_pending_q <= 1'b1;
            value_q        <= IvBase;
            main_q         <= LAMP_G;
            side_q         <= LAMP_R;
            walk_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            start_prev_q   <= start_q;
            load_pending_q <= 1'b0;
            value_q        <= value_d;
            main_q         <= main_d;
            side_q         <= side_d;
            walk_q         <= walk_d;
        end
    end

    assign start_timer = start_q;
    assign value       = value_q;
    assign main_lights = main_q;
    assign side_lights = side_q;
    assign walk        = walk_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with a small countdown-timer model.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       Reset_Sync = 1'b1;
    logic       expired;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;

    logic       use_model = 1'b1;
    logic       exp_force = 1'b0;
    logic [3:0] cnt;

    int checks = 0;
    int errors = 0;

    // Per-strobe expectation: {value, main_lights, side_lights, walk}
    localparam logic [10:0] E_MGA   = {4'd6, 3'b001, 3'b100, 1'b0};
    localparam logic [10:0] E_MGB6  = {4'd6, 3'b001, 3'b100, 1'b0};
    localparam logic [10:0] E_MGB3  = {4'd3, 3'b001, 3'b100, 1'b0};
    localparam logic [10:0] E_MY    = {4'd2, 3'b010, 3'b100, 1'b0};
    localparam logic [10:0] E_WALK  = {4'd3, 3'b100, 3'b100, 1'b1};
    localparam logic [10:0] E_SG    = {4'd6, 3'b100, 3'b001, 1'b0};
    localparam logic [10:0] E_SGEXT = {4'd3, 3'b100, 3'b001, 1'b0};
    localparam logic [10:0] E_SY    = {4'd2, 3'b100, 3'b010, 1'b0};

    traffic_light_fsm dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .expired      (expired),
        .sensor       (sensor),
        .walk_request (walk_request),
        .start_timer  (start_timer),
        .value        (value),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk         (walk)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (Reset_Sync)       cnt <= 4'd0;
        else if (start_timer) cnt <= value;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    assign expired = use_model ? (cnt == 4'd0) : exp_force;

    task automatic do_reset();
        @(negedge clk);
        Reset_Sync = 1'b1;
        repeat (2) @(negedge clk);
        Reset_Sync = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (start_timer === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        Reset_Sync = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_timer, value, main_lights, side_lights, walk} !== {1'b0, 4'd6, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %b want %b",
                     {start_timer, value, main_lights, side_lights, walk},
                     {1'b0, 4'd6, 3'b001, 3'b100, 1'b0});
        end
        Reset_Sync = 1'b0;
        @(negedge clk);
        checks++;
        if ({start_timer, value} !== {1'b1, 4'd6}) begin
            errors++;
            $display("FAIL reset_first_strobe got %b want %b", {start_timer, value}, {1'b1, 4'd6});
        end
    endtask

    task automatic test_normal();
        logic [10:0] exp_q [$];
        bit ok;
        exp_q = '{E_MGA, E_MGB6, E_MY, E_SG, E_SY, E_MGA};
        sensor = 1'b0;
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_strobe(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL normal[%0d] strobe timeout got none want %h", i, exp_q[i]);
                break;
            end
            if ({value, main_lights, side_lights, walk} !== exp_q[i]) begin
                errors++;
                $display("FAIL normal[%0d] got %h want %h", i,
                         {value, main_lights, side_lights, walk}, exp_q[i]);
            end
        end
    endtask

    task automatic test_sensor();
        logic [10:0] exp_q [$];
        bit ok;
        exp_q = '{E_MGA, E_MGB3, E_MY, E_SG, E_SGEXT, E_SY, E_MGA};
        sensor = 1'b1;
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_strobe(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sensor[%0d] strobe timeout got none want %h", i, exp_q[i]);
                break;
            end
            if ({value, main_lights, side_lights, walk} !== exp_q[i]) begin
                errors++;
                $display("FAIL sensor[%0d] got %h want %h", i,
                         {value, main_lights, side_lights, walk}, exp_q[i]);
            end
        end
        sensor = 1'b0;
    endtask

`ifdef TLC_WALK_EN
    task automatic test_walk();
        logic [10:0] exp_q [$];
        bit ok;
        exp_q = '{E_MGA, E_MGB6, E_MY, E_WALK, E_SG, E_SY, E_MGA, E_MGB6, E_MY, E_SG};
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_strobe(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL walk[%0d] strobe timeout got none want %h", i, exp_q[i]);
                break;
            end
            if ({value, main_lights, side_lights, walk} !== exp_q[i]) begin
                errors++;
                $display("FAIL walk[%0d] got %h want %h", i,
                         {value, main_lights, side_lights, walk}, exp_q[i]);
            end
            if (i == 0) begin
                walk_request = 1'b1;
                @(negedge clk);
                walk_request = 1'b0;
            end
        end
    endtask

    task automatic test_walk_coincide();
        logic [10:0] exp_q [$];
        bit ok;
        exp_q = '{E_MGA, E_MGB6, E_MY, E_WALK, E_SG, E_SY, E_MGA, E_MGB6, E_MY, E_WALK, E_SG};
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_strobe(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL walk_coincide[%0d] strobe timeout got none want %h", i, exp_q[i]);
                break;
            end
            if ({value, main_lights, side_lights, walk} !== exp_q[i]) begin
                errors++;
                $display("FAIL walk_coincide[%0d] got %h want %h", i,
                         {value, main_lights, side_lights, walk}, exp_q[i]);
            end
            // Request held through MY and across the WALK entry edge.
            if (i == 0 || i == 2) walk_request = 1'b1;
            if (i == 1 || i == 3) walk_request = 1'b0;
        end
        walk_request = 1'b0;
    endtask
`else
    task automatic test_no_walk();
        logic [10:0] exp_q [$];
        bit ok;
        exp_q = '{E_MGA, E_MGB6, E_MY, E_SG, E_SY, E_MGA};
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_strobe(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL no_walk[%0d] strobe timeout got none want %h", i, exp_q[i]);
                break;
            end
            if ({value, main_lights, side_lights, walk} !== exp_q[i]) begin
                errors++;
                $display("FAIL no_walk[%0d] got %h want %h", i,
                         {value, main_lights, side_lights, walk}, exp_q[i]);
            end
            walk_request = (i < 3);
        end
        walk_request = 1'b0;
    endtask
`endif

    task automatic test_expired_held();
        logic [7:0] exp_q [$];
        // Per cycle after release: {start_timer, value, main_lights}
        exp_q = '{{1'b1, 4'd6, 3'b001}, {1'b0, 4'd6, 3'b001}, {1'b0, 4'd6, 3'b001},
                  {1'b1, 4'd6, 3'b001}, {1'b0, 4'd6, 3'b001}, {1'b0, 4'd6, 3'b001},
                  {1'b1, 4'd2, 3'b010}};
        sensor    = 1'b0;
        use_model = 1'b0;
        exp_force = 1'b1;
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({start_timer, value, main_lights} !== exp_q[i]) begin
                errors++;
                $display("FAIL expired_held[%0d] got %b want %b", i,
                         {start_timer, value, main_lights}, exp_q[i]);
            end
        end
        exp_force = 1'b0;
        use_model = 1'b1;
    endtask

    task automatic test_reset_mid_sg();
        bit ok;
        wait_strobe(ok);
        checks++;
        if (!ok || {value, main_lights, side_lights} !== {4'd6, 3'b100, 3'b001}) begin
            errors++;
            $display("FAIL reset_mid_sg_entry got ok=%0d %h want ok=1 %h", ok,
                     {value, main_lights, side_lights}, {4'd6, 3'b100, 3'b001});
        end
        repeat (2) @(negedge clk);
        Reset_Sync = 1'b1;
        @(negedge clk);
        checks++;
        if ({start_timer, value, main_lights, side_lights, walk} !== {1'b0, 4'd6, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_sg_abort got %b want %b",
                     {start_timer, value, main_lights, side_lights, walk},
                     {1'b0, 4'd6, 3'b001, 3'b100, 1'b0});
        end
        Reset_Sync = 1'b0;
        @(negedge clk);
        checks++;
        if ({start_timer, value} !== {1'b1, 4'd6}) begin
            errors++;
            $display("FAIL reset_mid_sg_restart got %b want %b", {start_timer, value}, {1'b1, 4'd6});
        end
        @(negedge clk);
        checks++;
        if (start_timer !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sg_single_strobe got %b want 0", start_timer);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_sensor();
`ifdef TLC_WALK_EN
        test_walk();
        test_walk_coincide();
`else
        test_no_walk();
`endif
        test_expired_held();
        test_reset_mid_sg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Main/side-street traffic light sequencer, directly downstream and upstream of the countdown timer. It consumes the timer's `expired` flag and drives `start_timer` plus the 4-bit interval `value` that the timer loads. It also drives the main-street, side-street and walk lamps from the side-street vehicle sensor and pedestrian request inputs.

## Interface

**Parameters**

- `T_BASE`, default 6: base green interval, in seconds.
- `T_EXT`, default 3: extension interval and walk interval, in seconds.
- `T_YEL`, default 2: yellow interval, in seconds.

**Ports**

- `clk`  in  1  system clock.
- `Reset_Sync`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `expired`  in  1  timer countdown done, treated as a level.
- `sensor`  in  1  side-street vehicle present, level.
- `walk_request`  in  1  pedestrian button, any-length pulse.
- `start_timer`  out  1  one-cycle timer load strobe.
- `value`  out  4  interval for the timer to load; valid while `start_timer` is high and held until the next strobe.
- `main_lights`  out  3  {R,Y,G}.
- `side_lights`  out  3  {R,Y,G}.
- `walk`  out  1  walk lamp.

## Operation

**States, with lamps and loaded interval**

- MG_A: main G, side R, load T_BASE. On expiry go to MG_B.
- MG_B: main G, side R. Load T_EXT if `sensor` is 1 on the entry cycle, else T_BASE. On expiry go to MY.
- MY: main Y, side R, load T_YEL. On expiry go to WALK if the walk latch is set, else to SG.
- WALK: both R, `walk`=1, load T_EXT. The walk latch clears on entry. On expiry go to SG.
- SG: side G, main R, load T_BASE. On expiry go to SG_EXT if `sensor`=1 at that expiry, else to SY.
- SG_EXT: side G, main R, load T_EXT. On expiry go to SY.
- SY: side Y, main R, load T_YEL. On expiry go to MG_A.

**Walk latch**

- Sets on any cycle where `walk_request`=1.
- Clears on WALK entry.
- If set and clear occur in the same cycle, set wins, so one more walk phase is served in the next cycle of the sequence.

**Expiry qualification**

- `expired` is acted on only when `start_timer`=0 in both the current and the previous cycle.
- This guard masks stale expiry during the timer reload.

**Interval arithmetic**

- Parameters are truncated to 4 bits.
- A value of 0 is legal; the FSM relies only on `expired`.

**Reset**

- While `Reset_Sync`=1: state MG_A, `start_timer`=0, `value`=T_BASE, `main_lights`=3'b001, `side_lights`=3'b100, `walk`=0, walk latch cleared.
- Reset asserted mid-interval aborts the interval immediately.

## Timing

- All outputs are registered.
- First cycle after `Reset_Sync` falls: `start_timer`=1 with `value`=T_BASE.
- If a qualified `expired` is sampled in cycle N, the following change together in cycle N+1:
  - new state,
  - new lamps,
  - `start_timer`=1,
  - new `value`.
- `start_timer` is never high for two consecutive cycles.
- `sensor` is sampled only on the entry cycle of MG_B and on the SG expiry cycle. It is ignored at all other times.

## Configuration

**`TLC_WALK_EN` defined**

- WALK state and walk latch are present, as described above.

**`TLC_WALK_EN` undefined**

- `walk_request` is ignored.
- `walk` is tied to 0.
- WALK state is absent and MY always goes to SG.
- Ports are unchanged in both builds.

## Structure

- Package `tlc_pkg` holds:
  - the state enum,
  - lamp encoding constants (`LAMP_R`=3'b100, `LAMP_Y`=3'b010, `LAMP_G`=3'b001),
  - the 4-bit interval type.
- One sub-module, `walk_register`, contains the set-dominant walk latch and is instantiated only under `TLC_WALK_EN`.

## Test plan

- Reset, then no sensor and no walk, with a timer model: strobes load 6, 6, 2, 6, 2, 6. Lamps cycle MG_A → MG_B → MY → SG → SY → MG_A.
- `sensor`=1 throughout: MG_B loads 3, and SG is followed by SG_EXT loading 3 before SY loads 2.
- `walk_request` pulses one cycle during MG_A: after MY, WALK is entered with `walk`=1 and both lamps R, loading 3. The following cycle goes through SG with no second WALK.
- `walk_request` coincides with the WALK entry cycle: the latch stays set and WALK repeats on the next MY exit. With `TLC_WALK_EN` undefined, no WALK ever occurs and `walk`=0.
- `expired` held high across a strobe, and `Reset_Sync` pulsed during SG: no transition in the strobe cycle or the cycle after it. Reset returns MG_A lamps on the next edge and `start_timer`=1 with `value`=6 one cycle after release.
